// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the background pixel path.
// Contents: ppu_pixel_t (2-bit colour index), BgFifoState (FIFO FSM states),
// X_MAX (visible pixels per line), TILE_W (pixels per tile row) and derived widths.
package ppu_pkg;

    localparam int X_MAX = 160;
    localparam int TILE_W = 8;
    localparam int X_W = $clog2(X_MAX);
    localparam int CNT_W = $clog2(TILE_W + 1);

    typedef logic [1:0] ppu_pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        DISCARD,
        OUTPUT
    } BgFifoState;

endpackage

// File: rtl/bg_fifo_shreg.sv
// 8-entry pixel shift register with occupancy count.
// Ports:
//   clk_in, rst_in  clock, asynchronous active-high reset
//   flush           drop all entries (count=0); highest priority
//   load            parallel-load a full tile row, count=TILE_W
//   shift           pop entry [0], shift the rest toward [0], count--
//   load_data       tile row; [0] is the leftmost pixel
//   head            current entry [0]
//   count           number of valid entries
//   empty           count==0
module bg_fifo_shreg
    import ppu_pkg::*;
(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush,
    input  logic                         load,
    input  logic                         shift,
    input  ppu_pixel_t [TILE_W-1:0]      load_data,
    output ppu_pixel_t                   head,
    output logic [CNT_W-1:0]             count,
    output logic                         empty
);

    ppu_pixel_t [TILE_W-1:0] entries;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            entries <= '0;
            count   <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (load) begin
            entries <= load_data;
            count   <= CNT_W'(TILE_W);
        end else if (shift) begin
            entries <= {ppu_pixel_t'(0), entries[TILE_W-1:1]};
            count   <= count - CNT_W'(1);
        end
    end

    assign head  = entries[0];
    assign empty = (count == '0);

endmodule

// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: consumer side of the background fetcher push interface.
// Accepts a tile row only when empty, discards SCX[2:0] pixels at line start,
// then emits one pixel per enabled T-cycle with its X position, ending the line at X_MAX.
// Optional feature (macro BG_FIFO_WINDOW_FLUSH_EN): window_start_in in OUTPUT
// flushes staged pixels without emitting them; X is kept.
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   tclk_in            T-cycle enable; all state advances only when high
//   line_start_in      flush and rearm for a new line (overrides everything else)
//   SCX_in             scroll X, [2:0] sampled at line start
//   shift_ena_in       mixer permits a pop
//   valid_pixels_in    fetcher row valid
//   pixels_in          tile row, [0] leftmost
//   window_start_in    window trigger (only with BG_FIFO_WINDOW_FLUSH_EN)
//   bg_fifo_empty_out  FIFO empty
//   pixel_valid_out    strobe: pixel_out / pixel_x_out valid
//   pixel_out          emitted colour index
//   pixel_x_out        X of emitted pixel
//   line_done_out      strobe with pixel X_MAX-1
//
// state   | meaning
// IDLE    | line finished or not started; no push, no pop
// DISCARD | popping and dropping SCX fine-scroll pixels
// OUTPUT  | popping and emitting pixels, X counting up
module bg_pixel_fifo
    import ppu_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     tclk_in,
    input  logic                     line_start_in,
    input  logic [7:0]               SCX_in,
    input  logic                     shift_ena_in,
    input  logic                     valid_pixels_in,
    input  ppu_pixel_t [TILE_W-1:0]  pixels_in,
    input  logic                     window_start_in,
    output logic                     bg_fifo_empty_out,
    output logic                     pixel_valid_out,
    output ppu_pixel_t               pixel_out,
    output logic [X_W-1:0]           pixel_x_out,
    output logic                     line_done_out
);

    BgFifoState        state_q, state_d;
    logic [2:0]        discard_q, discard_d;
    logic [X_W-1:0]    x_q, x_d;
    logic              flush, push, pop, emit, last_px, win_flush;
    logic              empty;
    ppu_pixel_t        head;
    logic [CNT_W-1:0]  count;

`ifdef BG_FIFO_WINDOW_FLUSH_EN
    assign win_flush = window_start_in && (state_q == OUTPUT);
    logic unused_scx;
    assign unused_scx = &{1'b0, SCX_in[7:3]};
`else
    assign win_flush = 1'b0;
    logic unused_in;
    assign unused_in = &{1'b0, SCX_in[7:3], window_start_in};
`endif

    assign last_px = (x_q == X_W'(X_MAX - 1));

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        x_d       = x_q;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        emit      = 1'b0;
        if (tclk_in) begin
            if (line_start_in) begin
                flush     = 1'b1;
                x_d       = '0;
                discard_d = SCX_in[2:0];
                state_d   = (SCX_in[2:0] != 3'd0) ? DISCARD : OUTPUT;
            end else if (win_flush) begin
                // Pop suppressed: the staged pixels belong to the background, not the window.
                flush = 1'b1;
            end else begin
                push = valid_pixels_in && empty && (state_q != IDLE);
                pop  = shift_ena_in && !empty && (state_q != IDLE);
                if (pop) begin
                    case (state_q)
                        DISCARD: begin
                            discard_d = discard_q - 3'd1;
                            if (discard_q == 3'd1) state_d = OUTPUT;
                        end
                        OUTPUT: begin
                            emit = 1'b1;
                            if (last_px) state_d = IDLE;      // x saturates, never wraps
                            else         x_d     = x_q + X_W'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            discard_q <= '0;
            x_q       <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            x_q       <= x_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
            pixel_out       <= '0;
            pixel_x_out     <= '0;
        end else begin
            pixel_valid_out <= emit;
            line_done_out   <= emit && last_px;
            if (emit) begin
                pixel_out   <= head;
                pixel_x_out <= x_q;
            end
        end
    end

    bg_fifo_shreg u_shreg (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush     (flush),
        .load      (push),
        .shift     (pop),
        .load_data (pixels_in),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    assign bg_fifo_empty_out = empty;

endmodule

// File: tb/tb_bg_pixel_fifo.sv
module tb_bg_pixel_fifo;
    import ppu_pkg::*;

    typedef ppu_pixel_t [TILE_W-1:0] row_t;

    typedef struct {
        logic       tclk;
        logic       ls;
        logic [7:0] scx;
        logic       sh;
        logic       vld;
        row_t       pix;
        logic       e_vld;
        ppu_pixel_t e_pix;
        logic [7:0] e_x;
        logic       e_done;
        logic       e_empty;
    } vec_t;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            tclk_in, line_start_in, shift_ena_in, valid_pixels_in, window_start_in;
    logic [7:0]      SCX_in;
    row_t            pixels_in;
    logic            bg_fifo_empty_out, pixel_valid_out, line_done_out;
    ppu_pixel_t      pixel_out;
    logic [X_W-1:0]  pixel_x_out;

    int n_checks = 0;
    int n_fail = 0;

    bg_pixel_fifo dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .tclk_in           (tclk_in),
        .line_start_in     (line_start_in),
        .SCX_in            (SCX_in),
        .shift_ena_in      (shift_ena_in),
        .valid_pixels_in   (valid_pixels_in),
        .pixels_in         (pixels_in),
        .window_start_in   (window_start_in),
        .bg_fifo_empty_out (bg_fifo_empty_out),
        .pixel_valid_out   (pixel_valid_out),
        .pixel_out         (pixel_out),
        .pixel_x_out       (pixel_x_out),
        .line_done_out     (line_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic t, input logic ls, input logic [7:0] scx,
                         input logic sh, input logic vld, input row_t pix);
        tclk_in = t; line_start_in = ls; SCX_in = scx;
        shift_ena_in = sh; valid_pixels_in = vld; pixels_in = pix;
    endtask

    function automatic vec_t mk(logic t, logic ls, logic [7:0] scx, logic sh, logic vld, row_t pix,
                                logic ev, ppu_pixel_t ep, logic [7:0] ex, logic ed, logic ee);
        vec_t v;
        v.tclk = t; v.ls = ls; v.scx = scx; v.sh = sh; v.vld = vld; v.pix = pix;
        v.e_vld = ev; v.e_pix = ep; v.e_x = ex; v.e_done = ed; v.e_empty = ee;
        return v;
    endfunction

    function automatic row_t mkrow(input int e0, e1, e2, e3, e4, e5, e6, e7);
        row_t r;
        r[0] = ppu_pixel_t'(e0); r[1] = ppu_pixel_t'(e1); r[2] = ppu_pixel_t'(e2); r[3] = ppu_pixel_t'(e3);
        r[4] = ppu_pixel_t'(e4); r[5] = ppu_pixel_t'(e5); r[6] = ppu_pixel_t'(e6); r[7] = ppu_pixel_t'(e7);
        return r;
    endfunction

    function automatic row_t pat(input int r);
        row_t row;
        for (int i = 0; i < TILE_W; i++) row[i] = ppu_pixel_t'((r * 3 + i) % 4);
        return row;
    endfunction

    vec_t vt[$];
    row_t r0, ra, rb, r1, r2, zero_row, all0, all3;
    int   exp_a[3] = '{2, 1, 0};
    int   exp_1[8] = '{3, 0, 2, 1, 1, 2, 0, 3};
    int   n_px, done_cnt;
    bit   found;

    initial begin
        zero_row = '0;
        r0 = mkrow(0, 1, 2, 3, 0, 1, 2, 3);
        ra = mkrow(0, 1, 2, 3, 3, 2, 1, 0);
        rb = mkrow(1, 1, 2, 2, 3, 3, 0, 0);
        r1 = mkrow(3, 0, 2, 1, 1, 2, 0, 3);
        r2 = mkrow(0, 3, 1, 2, 2, 1, 3, 0);
        all0 = '0;
        all3 = mkrow(3, 3, 3, 3, 3, 3, 3, 3);

        vt.push_back(mk(1, 1, 8'd0, 0, 0, r0, 0, 0, 0, 0, 1));
        vt.push_back(mk(1, 0, 8'd0, 0, 1, r0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'd0, 1, 0, r0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1, 0, 8'd0, 1, 0, r0, 1, ppu_pixel_t'(i % 4), 8'(i), 0, (i == 7)));

        window_start_in = 1'b0;
        drive(0, 0, 8'd0, 0, 0, zero_row);
        rst_in = 1'b1;
        repeat (2) tick();
        chk("rst empty", bg_fifo_empty_out, 1);
        chk("rst valid", pixel_valid_out, 0);
        chk("rst done", line_done_out, 0);
        chk("rst pixel", pixel_out, 0);
        chk("rst x", pixel_x_out, 0);
        rst_in = 1'b0;
        tick();

        // Basic emission, SCX=0
        for (int k = 0; k < vt.size(); k++) begin
            drive(vt[k].tclk, vt[k].ls, vt[k].scx, vt[k].sh, vt[k].vld, vt[k].pix);
            tick();
            chk($sformatf("vec%0d valid", k), pixel_valid_out, vt[k].e_vld);
            chk($sformatf("vec%0d done", k), line_done_out, vt[k].e_done);
            chk($sformatf("vec%0d empty", k), bg_fifo_empty_out, vt[k].e_empty);
            if (vt[k].e_vld) begin
                chk($sformatf("vec%0d pixel", k), pixel_out, vt[k].e_pix);
                chk($sformatf("vec%0d x", k), pixel_x_out, vt[k].e_x);
            end
        end

        // Asynchronous reset mid-line with count=5
        drive(1, 1, 8'd0, 0, 0, r0); tick();
        drive(1, 0, 8'd0, 0, 1, r0); tick();
        drive(1, 0, 8'd0, 1, 0, r0);
        repeat (3) tick();
        chk("pre-reset valid", pixel_valid_out, 1);
        chk("pre-reset empty", bg_fifo_empty_out, 0);
        drive(0, 0, 8'd0, 0, 0, r0);
        #2 rst_in = 1'b1;
        #1;
        chk("async rst empty", bg_fifo_empty_out, 1);
        chk("async rst valid", pixel_valid_out, 0);
        tick();
        chk("rst clk empty", bg_fifo_empty_out, 1);
        chk("rst clk valid", pixel_valid_out, 0);
        chk("rst clk done", line_done_out, 0);
        chk("rst clk x", pixel_x_out, 0);
        rst_in = 1'b0;
        tick();

        // SCX=5 discard, then second row continues at x=3
        drive(1, 1, 8'd5, 0, 0, ra); tick();
        drive(1, 0, 8'd0, 0, 1, ra); tick();
        chk("scx push empty", bg_fifo_empty_out, 0);
        drive(1, 0, 8'd0, 1, 0, ra);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("scx discard%0d valid", i), pixel_valid_out, 0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("scx emit%0d valid", i), pixel_valid_out, 1);
            chk($sformatf("scx emit%0d x", i), pixel_x_out, i);
            chk($sformatf("scx emit%0d pixel", i), pixel_out, exp_a[i]);
        end
        chk("scx row end empty", bg_fifo_empty_out, 1);
        drive(1, 0, 8'd0, 1, 1, rb); tick();
        chk("scx reload valid", pixel_valid_out, 0);
        drive(1, 0, 8'd0, 1, 0, rb); tick();
        chk("scx row2 valid", pixel_valid_out, 1);
        chk("scx row2 x", pixel_x_out, 3);
        chk("scx row2 pixel", pixel_out, 1);

        // Held valid loads once; shift_ena stall mid-row
        drive(1, 1, 8'd0, 0, 0, r1); tick();
        drive(1, 0, 8'd0, 0, 1, r1); tick();
        chk("hold push empty", bg_fifo_empty_out, 0);
        drive(1, 0, 8'd0, 0, 1, r2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d valid", i), pixel_valid_out, 0);
        end
        drive(1, 0, 8'd0, 1, 0, r2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold pop%0d x", i), pixel_x_out, i);
            chk($sformatf("hold pop%0d pixel", i), pixel_out, exp_1[i]);
        end
        shift_ena_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stall%0d valid", i), pixel_valid_out, 0);
            chk($sformatf("stall%0d empty", i), bg_fifo_empty_out, 0);
        end
        shift_ena_in = 1'b1;
        for (int i = 3; i < 8; i++) begin
            tick();
            chk($sformatf("resume%0d valid", i), pixel_valid_out, 1);
            chk($sformatf("resume%0d x", i), pixel_x_out, i);
            chk($sformatf("resume%0d pixel", i), pixel_out, exp_1[i]);
        end
        chk("resume end empty", bg_fifo_empty_out, 1);

        // Full line: 160 pixels, line_done at x=159, nothing after
        drive(1, 1, 8'd0, 0, 0, pat(0)); tick();
        drive(1, 0, 8'd0, 1, 1, pat(0));
        n_px = 0; done_cnt = 0;
        for (int c = 0; c < 230; c++) begin
            tick();
            if (line_done_out) begin
                done_cnt++;
                chk("line_done x", pixel_x_out, X_MAX - 1);
                chk("line_done valid", pixel_valid_out, 1);
            end
            if (pixel_valid_out) begin
                chk($sformatf("line px%0d x", n_px), pixel_x_out, n_px);
                chk($sformatf("line px%0d pixel", n_px), pixel_out, pat(n_px / 8)[n_px % 8]);
                n_px++;
                if (n_px % 8 == 0) pixels_in = pat(n_px / 8);
            end
        end
        chk("line strobe count", n_px, X_MAX);
        chk("line_done count", done_cnt, 1);
        chk("idle after line empty", bg_fifo_empty_out, 1);

`ifdef BG_FIFO_WINDOW_FLUSH_EN
        // Window flush at x=20 with 3 staged pixels
        drive(1, 1, 8'd1, 0, 0, all0); tick();
        drive(1, 0, 8'd0, 1, 1, all0);
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            tick();
            if (pixel_valid_out && pixel_x_out == X_W'(19)) found = 1;
        end
        chk("win reach x19", found, 1);
        window_start_in = 1'b1;
        pixels_in = all3;
        tick();
        chk("win flush valid", pixel_valid_out, 0);
        chk("win flush empty", bg_fifo_empty_out, 1);
        window_start_in = 1'b0;
        tick();
        chk("win reload valid", pixel_valid_out, 0);
        tick();
        chk("win next valid", pixel_valid_out, 1);
        chk("win next x", pixel_x_out, 20);
        chk("win next pixel", pixel_out, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
